// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch into a small instruction buffer,
// with redirect flush and stale-response draining.

// Generic synchronous FIFO with flush; head is presented from storage.
// Latency: write in cycle N is visible at rd_dat/rd_vld in cycle N+1.
// Backpressure: none internally; the writer must never push when full.
module ifu_fifo #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_vld,
  input  logic [WIDTH-1:0]             wr_dat,
  output logic                         rd_vld,
  input  logic                         rd_rdy,
  output logic [WIDTH-1:0]             rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign do_pop = rd_vld & rd_rdy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= CNT_W'(SUM_W'(count) + SUM_W'(wr_vld) - SUM_W'(do_pop));
    end
  end

endmodule

// Fetch unit: issues word fetches while outstanding + buffered < DEPTH, buffers responses.
// Latency: response in cycle N is offered to the decoder in cycle N+1.
// Backpressure: instr_ready stalls the buffer, which withholds credits and so stops requests.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ibuf_entry_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        fetch_pc;
  logic [31:0]        fetch_pc_nxt;
  logic [31:0]        resp_pc;
  logic [31:0]        resp_pc_nxt;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   outstanding_nxt;
  logic [CNT_W-1:0]   drop_count;
  logic [CNT_W-1:0]   drop_count_nxt;
  logic [CNT_W-1:0]   buf_count;
  logic [CNT_W-1:0]   buf_count_nxt;
  logic               req_valid_nxt;
  logic               req_fire;
  logic               resp_take;
  logic               pop;
  logic [31:0]        redirect_tgt;
  ibuf_entry_t        push_dat;
  ibuf_entry_t        head_dat;

  assign imem_req_addr = fetch_pc;
  assign instr         = head_dat.word;
  assign instr_pc      = head_dat.pc;
  assign push_dat      = '{pc: resp_pc, word: imem_resp_data};

  ifu_fifo #(
    .WIDTH     ($bits(ibuf_entry_t)),
    .DEPTH     (DEPTH),
    .RESET_VAL ({RESET_PC, 32'h0000_0000})
  ) u_ibuf (
    .clk    (clk),
    .reset  (reset),
    .flush  (redirect_valid),
    .wr_vld (resp_take),
    .wr_dat (push_dat),
    .rd_vld (instr_valid),
    .rd_rdy (instr_ready),
    .rd_dat (head_dat),
    .count  (buf_count)
  );

  always_comb begin
    req_fire     = imem_req_valid & imem_req_ready;
    pop          = instr_valid & instr_ready;
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    // A response is only kept if it belongs to the current fetch stream.
    resp_take    = imem_resp_valid & ~redirect_valid & (drop_count == '0);

    // Every response retires one outstanding request, stale or not.
    outstanding_nxt = CNT_W'(SUM_W'(outstanding) + SUM_W'(req_fire) - SUM_W'(imem_resp_valid));

    buf_count_nxt = redirect_valid ? '0
                  : CNT_W'(SUM_W'(buf_count) + SUM_W'(resp_take) - SUM_W'(pop));

    drop_count_nxt = drop_count;
    if (redirect_valid) begin
      drop_count_nxt = outstanding_nxt;
    end else if (imem_resp_valid && (drop_count != '0)) begin
      drop_count_nxt = drop_count - CNT_W'(1);
    end

    fetch_pc_nxt = fetch_pc;
    resp_pc_nxt  = resp_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_tgt;
      resp_pc_nxt  = redirect_tgt;
    end else begin
      if (req_fire)  fetch_pc_nxt = fetch_pc + 32'd4;
      if (resp_take) resp_pc_nxt  = resp_pc + 32'd4;
    end

    state_nxt = state;
    case (state)
      IDLE: state_nxt = RUN;
      RUN, DRAIN: begin
        if (redirect_valid) begin
          state_nxt = (drop_count_nxt != '0) ? DRAIN : RUN;
        end else if ((state == DRAIN) && (drop_count_nxt == '0)) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    req_valid_nxt = (state_nxt == RUN) &&
                    ((SUM_W'(outstanding_nxt) + SUM_W'(buf_count_nxt)) < SUM_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      outstanding    <= '0;
      drop_count     <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      fetch_pc       <= fetch_pc_nxt;
      resp_pc        <= resp_pc_nxt;
      outstanding    <= outstanding_nxt;
      drop_count     <= drop_count_nxt;
      imem_req_valid <= req_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic against
// a stream-level model (epoch-tagged in-flight requests, decoder PC sequence).
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  // Model of the fetch stream
  mreq_t       inflight[$];
  int          buf_cnt;
  int          epoch;
  logic [31:0] fetch_addr;
  logic [31:0] dec_pc;
  bit          started;
  int          cyc;
  int          last_due;

  // Stimulus controls
  int          p_req_rdy;
  int          p_instr_rdy;
  int          lat_lo;
  int          lat_hi;
  bit          redir_now;
  logic [31:0] redir_tgt_in;

  // Observed DUT handshakes
  int          obs_fires;
  logic [31:0] obs_last_fire_addr;
  int          obs_pops;
  logic [31:0] obs_last_pop_pc;

  int n_total;
  int n_pass;
  int n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expired(input string tag);
    n_total++;
    n_fail++;
    $error("FAIL %s: observed no event within cycle budget, expected event", tag);
  endtask

  // One clock cycle, entered and left just after the falling edge.
  task automatic step();
    bit    draining;
    bit    exp_rv;
    bit    exp_iv;
    bit    resp;
    bit    fire;
    bit    pop;
    int    d;
    mreq_t m;

    draining = 1'b0;
    foreach (inflight[i]) if (inflight[i].epoch != epoch) draining = 1'b1;
    exp_rv = started && !draining && ((inflight.size() + buf_cnt) < DEPTH);
    exp_iv = (buf_cnt != 0);

    check("req_valid", imem_req_valid, exp_rv);
    check("instr_valid", instr_valid, exp_iv);
    if (exp_rv) check("req_addr", imem_req_addr, fetch_addr);
    if (exp_iv) begin
      check("instr_pc", instr_pc, dec_pc);
      check("instr", instr, mem_word(dec_pc));
    end

    imem_req_ready = ($urandom_range(99) < p_req_rdy);
    instr_ready    = ($urandom_range(99) < p_instr_rdy);
    redirect_valid = redir_now;
    redirect_pc    = redir_tgt_in;
    redir_now      = 1'b0;
    resp = (inflight.size() != 0) && (inflight[0].due == cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(inflight[0].addr) : $urandom;

    if (imem_req_valid && imem_req_ready) begin
      obs_fires++;
      obs_last_fire_addr = imem_req_addr;
    end
    if (instr_valid && instr_ready) begin
      obs_pops++;
      obs_last_pop_pc = instr_pc;
    end

    fire = exp_rv && imem_req_ready;
    pop  = exp_iv && instr_ready;
    if (resp) begin
      m = inflight.pop_front();
      if (!redirect_valid && (m.epoch == epoch)) buf_cnt++;
    end
    if (pop) begin
      buf_cnt--;
      dec_pc += 32'd4;
    end
    if (fire) begin
      d = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      inflight.push_back('{addr: fetch_addr, epoch: epoch, due: d});
      fetch_addr += 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      buf_cnt    = 0;
      fetch_addr = redirect_pc & 32'hFFFF_FFFC;
      dec_pc     = redirect_pc & 32'hFFFF_FFFC;
    end

    @(posedge clk);
    @(negedge clk);
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    cyc++;
    started = 1'b1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    redir_now       = 1'b0;
    inflight.delete();
    buf_cnt    = 0;
    epoch      = 0;
    fetch_addr = RESET_PC;
    dec_pc     = RESET_PC;
    started    = 1'b0;
    last_due   = -1;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, RESET_PC);
    reset = 1'b0;
  endtask

  initial begin
    int f0;
    int p0;
    n_total = 0; n_pass = 0; n_fail = 0;
    obs_fires = 0; obs_pops = 0; cyc = 0;
    p_req_rdy = 100; p_instr_rdy = 100; lat_lo = 0; lat_hi = 0;
    redir_tgt_in = '0;
    reset = 1'b1;
    @(negedge clk);

    // Streaming with a single-cycle memory
    do_reset();
    p0 = obs_pops;
    for (int k = 0; k < 30 && (obs_pops - p0) < 3; k++) step();
    if ((obs_pops - p0) < 3) expired("r032_pops");
    else check("r032_third_pc", obs_last_pop_pc, 32'h8);

    // Decoder stalled: credits cap requests at DEPTH
    do_reset();
    p_instr_rdy = 0;
    f0 = obs_fires;
    for (int k = 0; k < 10; k++) step();
    check("r033_fires", obs_fires - f0, DEPTH);
    check("r033_req_low", imem_req_valid, 1'b0);
    check("r033_buf_full", instr_valid, 1'b1);
    p_instr_rdy = 100;
    step();
    p_instr_rdy = 0;
    for (int k = 0; k < 8; k++) step();
    check("r033_one_more", obs_fires - f0, DEPTH + 1);

    // Memory stall at address 8
    do_reset();
    p_instr_rdy = 100;
    for (int k = 0; k < 20 && !(imem_req_valid && imem_req_addr == 32'h8); k++) step();
    if (!(imem_req_valid && imem_req_addr == 32'h8)) expired("r034_reach8");
    else begin
      p_req_rdy = 0;
      f0 = obs_fires;
      for (int k = 0; k < 3; k++) begin
        check("r034_addr_hold", imem_req_addr, 32'h8);
        step();
      end
      check("r034_no_dup", obs_fires - f0, 0);
      p_req_rdy = 100;
      step();
      check("r034_issue8", obs_last_fire_addr, 32'h8);
    end

    // Redirect with two requests outstanding
    do_reset();
    p_instr_rdy = 100; lat_lo = 3; lat_hi = 3;
    for (int k = 0; k < 20 && inflight.size() < 2; k++) step();
    if (inflight.size() < 2) expired("r035_two_out");
    else begin
      p_req_rdy = 0;
      redir_now = 1'b1;
      redir_tgt_in = 32'h103;
      step();
      check("r035_drain_no_req", imem_req_valid, 1'b0);
      p_req_rdy = 100;
      f0 = obs_fires;
      p0 = obs_pops;
      for (int k = 0; k < 40 && obs_fires == f0; k++) step();
      if (obs_fires == f0) expired("r035_next_req");
      else check("r035_next_addr", obs_last_fire_addr, 32'h100);
      for (int k = 0; k < 40 && obs_pops == p0; k++) step();
      if (obs_pops == p0) expired("r035_first_pop");
      else check("r035_first_pc", obs_last_pop_pc, 32'h100);
    end

    // Redirect coinciding with a response and a pop
    do_reset();
    lat_lo = 0; lat_hi = 0; p_instr_rdy = 0;
    for (int k = 0; k < 20 && !(buf_cnt == 1 && inflight.size() == 1 && inflight[0].due == cyc); k++) step();
    if (!(buf_cnt == 1 && inflight.size() == 1 && inflight[0].due == cyc)) expired("r036_setup");
    else begin
      p_instr_rdy = 100;
      redir_now = 1'b1;
      redir_tgt_in = 32'h40;
      step();
      check("r036_buf_empty", instr_valid, 1'b0);
      check("r036_no_drain", imem_req_valid, 1'b1);
      f0 = obs_fires;
      step();
      check("r036_target", obs_last_fire_addr, 32'h40);
      check("r036_one_fire", obs_fires - f0, 1);
    end

    // Randomized traffic, with one reset mid-run
    do_reset();
    lat_lo = 0; lat_hi = 3; p_req_rdy = 75; p_instr_rdy = 65;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (started && ($urandom_range(99) < 4)) begin
        redir_now    = 1'b1;
        redir_tgt_in = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: InstructionFetchUnit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries and maximum credits (outstanding requests plus buffered entries).
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  out  32  word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid  in  1  in-order response valid, one per accepted request, no backpressure.
REQ-009 SHALL have port imem_resp_data  in  32  fetched instruction word.
REQ-010 SHALL have port instr_valid  out  1  buffered instruction available to the decoder.
REQ-011 SHALL have port instr_ready  in  1  decoder consumes instruction.
REQ-012 SHALL have port instr  out  32  instruction word driven to the control extractor/decoder.
REQ-013 SHALL have port instr_pc  out  32  address of instr.
REQ-014 SHALL have port redirect_valid  in  1  branch/jump taken, one-cycle pulse.
REQ-015 SHALL have port redirect_pc  in  32  new fetch target; bits [1:0] ignored, forced to 0.

Function
REQ-016 SHALL use FSM states IDLE, RUN, DRAIN; IDLE -> RUN unconditionally one cycle after reset release.
REQ-017 SHALL assert imem_req_valid only in RUN and only when outstanding + buffer_count < DEPTH.
REQ-018 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 SHALL, on request handshake (valid & ready), increment fetch_pc by 4 (mod 2^32) and outstanding by 1.
REQ-020 SHALL, on a non-stale response, write {resp_pc, imem_resp_data} into the buffer tail, increment resp_pc by 4, decrement outstanding.
REQ-021 SHALL present the buffer head on instr/instr_pc with instr_valid = (buffer_count != 0); pop on instr_valid & instr_ready.
REQ-022 SHALL support push and pop in the same cycle, count unchanged; the credit rule in REQ-017 guarantees no overflow.
REQ-023 SHALL, on redirect_valid, flush the buffer, set fetch_pc and resp_pc to {redirect_pc[31:2],2'b00}, and set drop_count = outstanding (including any request handshaking that same cycle, minus any response arriving that same cycle).
REQ-024 SHALL discard a response arriving in the redirect cycle, and discard later responses while drop_count > 0, decrementing drop_count each time.
REQ-025 SHALL, after redirect, enter DRAIN if drop_count > 0, else RUN; DRAIN -> RUN on the cycle drop_count reaches 0; no requests are issued in DRAIN.
REQ-026 SHALL treat a pop in the redirect cycle as a completed handshake; redirect has priority over the same-cycle push.
REQ-027 SHALL accept a redirect in DRAIN; it replaces the target and drop_count is recomputed per REQ-023.
REQ-028 SHALL have fetch-to-output latency of 1 cycle: response in cycle N -> instr_valid in cycle N+1.
REQ-029 SHALL size counters as clog2(DEPTH+1) bits; outstanding never exceeds DEPTH.

Reset
REQ-030 SHALL, while reset=1, force state=IDLE, fetch_pc=resp_pc=RESET_PC, outstanding=drop_count=buffer_count=0, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=RESET_PC.
REQ-031 SHALL, on reset mid-operation, abandon in-flight requests; responses to them are the environment's responsibility and are not consumed.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory, instr_ready=1 -> addresses 0,4,8,... issued; instr_pc sequence 0,4,8 with matching data.
REQ-033 instr_ready=0 held -> exactly DEPTH (2) requests issued, then imem_req_valid=0 until a pop; after the pop, one new request.
REQ-034 imem_req_ready=0 for 3 cycles at addr 8 -> imem_req_addr stays 8, fetch_pc unchanged, no duplicate request.
REQ-035 Redirect to 32'h103 with 2 outstanding -> state DRAIN, 2 responses dropped, next request addr 32'h100, first instr_pc 32'h100.
REQ-036 Redirect in the same cycle as response arrival and pop -> response discarded, buffer empty next cycle, drop_count = outstanding - 1.
